// File: rtl/halton_pkg.sv
// Shared types and constants for the 2-D Halton point scheduler.
// State encoding is also exported on the top level as a debug output.
package halton_pkg;

    localparam int FRAC_W = 16;
    localparam int IDX_W  = 32;

    localparam logic [1:0] BASE_SEL_2 = 2'b00;
    localparam logic [1:0] BASE_SEL_3 = 2'b01;
    localparam logic [1:0] BASE_SEL_7 = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE0 = 3'd1,
        WAIT0  = 3'd2,
        ARM1   = 3'd3,
        ISSUE1 = 3'd4,
        WAIT1  = 3'd5,
        HOLD   = 3'd6,
        ERR    = 3'd7
    } state_t;

endpackage

// File: rtl/halton_watchdog.sv
// Loadable down-counter with an expire flag. The flag is raised while
// enabled and the count has reached zero.
module halton_watchdog #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_expired
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_expired = i_en && (r_cnt == '0);

endmodule

// File: rtl/halton2d_seq_ctrl.sv
// Time-shares one van der Corput core to build 2-D Halton points:
// per index k a dim0 job then a dim1 job, paired and offered on pt_valid/pt_ready.
module halton2d_seq_ctrl
    import halton_pkg::*;
#(
    parameter logic [1:0]       DIM0_BASE_SEL  = BASE_SEL_2,
    parameter logic [1:0]       DIM1_BASE_SEL  = BASE_SEL_3,
    parameter logic [IDX_W-1:0] K_START        = 32'd1,
    parameter int               TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              seed_we,
    input  logic [IDX_W-1:0]  seed_k,
    input  logic              err_clr,
    input  logic              core_ready,
    input  logic              core_done,
    input  logic [31:0]       core_result,
    output logic              core_start,
    output logic [IDX_W-1:0]  core_k,
    output logic [1:0]        core_base_sel,
    output logic              pt_valid,
    input  logic              pt_ready,
    output logic [FRAC_W-1:0] pt_x,
    output logic [FRAC_W-1:0] pt_y,
    output logic [IDX_W-1:0]  pt_k,
    output logic              busy,
    output logic              err,
    output logic [2:0]        dbg_state
);

    // Point handshake: a point transfers on a rising clk edge where pt_valid
    // and pt_ready are both high; pt_valid and the payload hold until then.

    localparam int WD_W = 32;
    // The counter is loaded while ISSUEx is active and checked from the
    // first WAITx cycle, so TIMEOUT_CYCLES-2 lands the error exactly
    // TIMEOUT_CYCLES cycles after core_start rises.
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 2);

    state_t             r_state;
    logic [IDX_W-1:0]   r_k;
    logic               r_done_q;
    logic               r_core_start;
    logic [IDX_W-1:0]   r_core_k;
    logic [1:0]         r_core_base_sel;
    logic               r_pt_valid;
    logic [FRAC_W-1:0]  r_pt_x;
    logic [FRAC_W-1:0]  r_pt_y;
    logic [IDX_W-1:0]   r_pt_k;
    logic               r_busy;
    logic               r_err;

    logic               w_done_rise;
    logic               w_in_wait;
    logic               w_wd_load;
    logic               w_wd_en;
    logic               w_wd_expired;
    logic [IDX_W-1:0]   w_k_next;
    logic               w_unused_hi;

    assign w_done_rise = core_done & ~r_done_q;
    assign w_in_wait   = (r_state == WAIT0) || (r_state == WAIT1);
    assign w_wd_load   = (r_state == ISSUE0) || (r_state == ISSUE1);
    assign w_wd_en     = w_in_wait & ~w_done_rise;
    assign w_k_next    = (r_k == 32'hFFFF_FFFF) ? K_START : (r_k + 32'd1);
    assign w_unused_hi = ^core_result[31:16];

    halton_watchdog #(
        .W (WD_W)
    ) u_watchdog (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_wd_load),
        .i_load_val (WD_LOAD),
        .i_en       (w_wd_en),
        .o_expired  (w_wd_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= IDLE;
            r_k             <= K_START;
            r_done_q        <= 1'b0;
            r_core_start    <= 1'b0;
            r_core_k        <= '0;
            r_core_base_sel <= '0;
            r_pt_valid      <= 1'b0;
            r_pt_x          <= '0;
            r_pt_y          <= '0;
            r_pt_k          <= '0;
            r_busy          <= 1'b0;
            r_err           <= 1'b0;
        end else begin
            r_done_q     <= core_done;
            r_core_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (seed_we) begin
                        r_k <= seed_k;
                    end else if (run && core_ready) begin
                        r_state         <= ISSUE0;
                        r_core_start    <= 1'b1;
                        r_core_k        <= r_k;
                        r_core_base_sel <= DIM0_BASE_SEL;
                        r_busy          <= 1'b1;
                    end
                end
                ISSUE0: r_state <= WAIT0;
                WAIT0: begin
                    if (w_done_rise) begin
                        r_pt_x  <= core_result[FRAC_W-1:0];
                        r_state <= ARM1;
                    end else if (w_wd_expired) begin
                        r_state <= ERR;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                ARM1: begin
                    if (core_ready) begin
                        r_state         <= ISSUE1;
                        r_core_start    <= 1'b1;
                        r_core_k        <= r_k;
                        r_core_base_sel <= DIM1_BASE_SEL;
                    end
                end
                ISSUE1: r_state <= WAIT1;
                WAIT1: begin
                    if (w_done_rise) begin
                        r_pt_y     <= core_result[FRAC_W-1:0];
                        r_pt_k     <= r_k;
                        r_pt_valid <= 1'b1;
                        r_state    <= HOLD;
                        r_busy     <= 1'b0;
                    end else if (w_wd_expired) begin
                        r_state <= ERR;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                HOLD: begin
                    // The next job may only start on the accepting edge,
                    // so core_start never overlaps a presented point.
                    if (pt_ready) begin
                        r_pt_valid <= 1'b0;
                        r_k        <= w_k_next;
                        if (run && core_ready) begin
                            r_state         <= ISSUE0;
                            r_core_start    <= 1'b1;
                            r_core_k        <= w_k_next;
                            r_core_base_sel <= DIM0_BASE_SEL;
                            r_busy          <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                ERR: begin
                    if (err_clr) begin
                        r_state <= IDLE;
                        r_err   <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign core_start    = r_core_start;
    assign core_k        = r_core_k;
    assign core_base_sel = r_core_base_sel;
    assign pt_valid      = r_pt_valid;
    assign pt_x          = r_pt_x;
    assign pt_y          = r_pt_y;
    assign pt_k          = r_pt_k;
    assign busy          = r_busy;
    assign err           = r_err;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_halton2d_seq_ctrl.sv
// Bench for halton2d_seq_ctrl: two instances (dim1 base 3 and base 7) driven
// by a behavioural core; a forked monitor pops expected points from queues.
module tb_halton2d_seq_ctrl;
    import halton_pkg::*;

    localparam int CORE_LAT = 3;

    logic clk;
    logic rst;

    logic        run[2], seed_we[2], err_clr[2], pt_ready[2];
    logic [31:0] seed_k[2];
    logic        core_ready[2], core_start[2], pt_valid[2], busy[2], err[2];
    logic [31:0] core_k[2], pt_k[2];
    logic [1:0]  core_base_sel[2];
    logic [15:0] pt_x[2], pt_y[2];
    logic [2:0]  dbg_state[2];

    logic        hang[2];
    logic        c_busy[2], c_done[2];
    logic [3:0]  c_cnt[2];
    logic [31:0] c_res[2], c_job_k[2];
    logic [1:0]  c_job_sel[2];

    // {check_y, k, x, y}
    logic [64:0] exp_q0[$];
    logic [64:0] exp_q1[$];
    int n_pass, n_chk;
    int hs_cnt[2];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    halton2d_seq_ctrl #(
        .DIM1_BASE_SEL  (2'b01),
        .TIMEOUT_CYCLES (16)
    ) u_dut0 (
        .clk (clk), .rst (rst), .run (run[0]), .seed_we (seed_we[0]), .seed_k (seed_k[0]),
        .err_clr (err_clr[0]), .core_ready (core_ready[0]), .core_done (c_done[0]),
        .core_result (c_res[0]), .core_start (core_start[0]), .core_k (core_k[0]),
        .core_base_sel (core_base_sel[0]), .pt_valid (pt_valid[0]), .pt_ready (pt_ready[0]),
        .pt_x (pt_x[0]), .pt_y (pt_y[0]), .pt_k (pt_k[0]), .busy (busy[0]), .err (err[0]),
        .dbg_state (dbg_state[0])
    );

    halton2d_seq_ctrl #(
        .DIM1_BASE_SEL  (2'b10)
    ) u_dut1 (
        .clk (clk), .rst (rst), .run (run[1]), .seed_we (seed_we[1]), .seed_k (seed_k[1]),
        .err_clr (err_clr[1]), .core_ready (core_ready[1]), .core_done (c_done[1]),
        .core_result (c_res[1]), .core_start (core_start[1]), .core_k (core_k[1]),
        .core_base_sel (core_base_sel[1]), .pt_valid (pt_valid[1]), .pt_ready (pt_ready[1]),
        .pt_x (pt_x[1]), .pt_y (pt_y[1]), .pt_k (pt_k[1]), .busy (busy[1]), .err (err[1]),
        .dbg_state (dbg_state[1])
    );

    // ---------------- behavioural core ----------------
    function automatic logic [31:0] rad_inv(input logic [31:0] k, input logic [1:0] sel);
        longint unsigned b, num, den, kk;
        b   = (sel == 2'b00) ? 2 : ((sel == 2'b01) ? 3 : 7);
        num = 0;
        den = 1;
        kk  = longint'(k);
        while (kk != 0) begin
            num = num * b + (kk % b);
            den = den * b;
            kk  = kk / b;
        end
        // Junk in the integer half: only the low 16 bits may be used.
        return {k[15:0] ^ 16'h5A5A, 16'((num << 16) / den)};
    endfunction

    assign core_ready[0] = ~c_busy[0];
    assign core_ready[1] = ~c_busy[1];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                c_busy[i] <= 1'b0; c_done[i] <= 1'b0; c_cnt[i] <= '0;
                c_res[i] <= '0; c_job_k[i] <= '0; c_job_sel[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                c_done[i] <= 1'b0;
                if (core_start[i] && !c_busy[i]) begin
                    c_busy[i]    <= 1'b1;
                    c_cnt[i]     <= 4'(CORE_LAT);
                    c_job_k[i]   <= core_k[i];
                    c_job_sel[i] <= core_base_sel[i];
                end else if (c_busy[i]) begin
                    if (c_cnt[i] == 4'd1) begin
                        c_busy[i] <= 1'b0;
                        c_done[i] <= !hang[i];
                        c_res[i]  <= rad_inv(c_job_k[i], c_job_sel[i]);
                    end else begin
                        c_cnt[i] <= c_cnt[i] - 4'd1;
                    end
                end
            end
        end
    end

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    endtask

    function automatic int qsize(input int i);
        return (i == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    task automatic push(input int i, input logic [31:0] k, input logic [15:0] x,
                        input logic [15:0] y, input logic cy);
        if (i == 0) exp_q0.push_back({cy, k, x, y});
        else        exp_q1.push_back({cy, k, x, y});
    endtask

    task automatic mon_one(input int i);
        logic [64:0] e;
        if (pt_valid[i]) chk("no_start_while_valid", 64'(core_start[i]), 64'(0));
        if (pt_valid[i] && pt_ready[i]) begin
            hs_cnt[i]++;
            if (qsize(i) == 0) begin
                n_chk++;
                $display("FAIL unexpected_point inst%0d: pt_k=0x%0h", i, pt_k[i]);
            end else begin
                if (i == 0) e = exp_q0.pop_front();
                else        e = exp_q1.pop_front();
                chk("pt_k", 64'(pt_k[i]), 64'(e[63:32]));
                chk("pt_x", 64'(pt_x[i]), 64'(e[31:16]));
                if (e[64]) chk("pt_y", 64'(pt_y[i]), 64'(e[15:0]));
            end
        end
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (!rst) begin
                mon_one(0);
                mon_one(1);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Keeps run high until the last queued point is on the port, then lets
    // the block fall back to IDLE once it is accepted.
    task automatic drain(input int i, input int budget, input string name);
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            step();
            if (pt_valid[i] && qsize(i) == 1) run[i] = 1'b0;
            if (qsize(i) == 0 && dbg_state[i] == IDLE) begin
                ok = 1'b1;
                break;
            end
        end
        run[i] = 1'b0;
        chk(name, 64'(ok), 64'(1));
    endtask

    task automatic wait_start(input int i, input string name);
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            step();
            if (core_start[i]) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, 64'(ok), 64'(1));
    endtask

    task automatic seed(input int i, input logic [31:0] k);
        seed_k[i]  = k;
        seed_we[i] = 1'b1;
        step();
        seed_we[i] = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic ok;
        int   c;
        n_pass = 0;
        n_chk  = 0;
        rst    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            run[i] = 1'b0; seed_we[i] = 1'b0; seed_k[i] = '0; err_clr[i] = 1'b0;
            pt_ready[i] = 1'b1; hang[i] = 1'b0; hs_cnt[i] = 0;
        end
        fork
            monitor_loop();
        join_none

        #12;
        chk("rst_core_start", 64'(core_start[0]), 64'(0));
        chk("rst_core_k", 64'(core_k[0]), 64'(0));
        chk("rst_pt", {31'd0, pt_valid[0], pt_x[0], pt_y[0]}, 64'(0));
        chk("rst_flags", {busy[0], err[0], dbg_state[0]}, 64'(0));
        chk("rst_inst1", {busy[1], err[1], pt_valid[1], core_start[1]}, 64'(0));
        #4;
        rst = 1'b0;
        step();

        // Three default points; run drops while point 3 is in flight.
        push(0, 32'd1, 16'h8000, 16'h5555, 1'b1);
        push(0, 32'd2, 16'h4000, 16'hAAAA, 1'b1);
        push(0, 32'd3, 16'hC000, 16'h1C71, 1'b1);
        run[0] = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            step();
            if (hs_cnt[0] >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        chk("two_handshakes", 64'(ok), 64'(1));
        run[0] = 1'b0;
        chk("run_low_mid_point_busy", 64'(busy[0]), 64'(1));
        drain(0, 200, "drain_defaults");

        // Seed 11 with run high in the same cycle: seed wins, stays IDLE.
        run[0] = 1'b1;
        seed(0, 32'd11);
        chk("seed_prio_state", 64'(dbg_state[0]), 64'(IDLE));
        chk("seed_prio_start", 64'(core_start[0]), 64'(0));
        push(0, 32'd11, 16'hD000, 16'hB425, 1'b1);
        drain(0, 200, "drain_seed11");

        seed(1, 32'd11);
        push(1, 32'd11, 16'hD000, 16'h9782, 1'b1);
        run[1] = 1'b1;
        drain(1, 200, "drain_seed11_b7");

        // Backpressure on k=12; a seed write in HOLD must be ignored.
        pt_ready[0] = 1'b0;
        push(0, 32'd12, 16'h3000, 16'h25ED, 1'b1);
        run[0] = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            step();
            if (pt_valid[0]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("bp_valid_seen", 64'(ok), 64'(1));
        for (int n = 0; n < 20; n++) begin
            chk("bp_hold_k", 64'(pt_k[0]), 64'(32'd12));
            chk("bp_hold_xy", {30'd0, pt_valid[0], core_start[0], pt_x[0], pt_y[0]},
                {30'd0, 1'b1, 1'b0, 16'h3000, 16'h25ED});
            if (n == 5) begin
                seed_k[0] = 32'd99;
                seed_we[0] = 1'b1;
            end else begin
                seed_we[0] = 1'b0;
            end
            step();
        end
        seed_we[0] = 1'b0;
        push(0, 32'd13, 16'hB000, 16'h7B42, 1'b1);
        pt_ready[0] = 1'b1;
        drain(0, 200, "drain_backpressure");

        // Core that never completes: watchdog, then retry of k=14.
        hang[0] = 1'b1;
        run[0]  = 1'b1;
        wait_start(0, "to_start_seen");
        chk("to_core_k", 64'(core_k[0]), 64'(32'd14));
        run[0] = 1'b0;
        c = 0;
        while (!err[0] && c < 40) begin
            step();
            c++;
            if (pt_valid[0]) chk("to_no_valid", 64'(pt_valid[0]), 64'(0));
        end
        chk("to_err_cycles", 64'(c), 64'(16));
        chk("to_state", 64'(dbg_state[0]), 64'(ERR));
        chk("to_busy_valid", {busy[0], pt_valid[0]}, 64'(0));
        hang[0]    = 1'b0;
        err_clr[0] = 1'b1;
        step();
        err_clr[0] = 1'b0;
        chk("clr_err", {err[0], dbg_state[0]}, 64'(0));
        push(0, 32'd14, 16'h7000, 16'hD097, 1'b1);
        run[0] = 1'b1;
        wait_start(0, "retry_start_seen");
        chk("retry_core_k", 64'(core_k[0]), 64'(32'd14));
        drain(0, 200, "drain_retry");

        // Index wrap from all-ones back to K_START.
        seed(0, 32'hFFFF_FFFF);
        push(0, 32'hFFFF_FFFF, 16'hFFFF, 16'h0000, 1'b0);
        push(0, 32'd1, 16'h8000, 16'h5555, 1'b1);
        run[0] = 1'b1;
        drain(0, 200, "drain_wrap");

        // Reset while waiting for the dim1 result of k=2.
        run[0] = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            step();
            if (dbg_state[0] == WAIT1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("reach_wait1", 64'(ok), 64'(1));
        rst = 1'b1;
        #1;
        chk("mid_rst_core", {29'd0, core_start[0], core_base_sel[0], core_k[0]}, 64'(0));
        chk("mid_rst_pt", {31'd0, pt_valid[0], pt_x[0], pt_y[0]}, 64'(0));
        chk("mid_rst_pt_k", 64'(pt_k[0]), 64'(0));
        chk("mid_rst_flags", {busy[0], err[0], dbg_state[0]}, 64'(0));
        chk("mid_rst_k_reg", 64'(u_dut0.r_k), 64'(32'd1));
        step();
        push(0, 32'd1, 16'h8000, 16'h5555, 1'b1);
        rst = 1'b0;
        drain(0, 200, "drain_after_rst");

        step();
        chk("q0_empty", 64'(exp_q0.size()), 64'(0));
        chk("q1_empty", 64'(exp_q1.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/halton2d_seq_ctrl.md
Name: halton2d_seq_ctrl

Overview:
Scheduler that time-shares one vdcorput_fsm_32bit_simple core to produce a 2-D Halton point stream. Per index k it issues two core jobs: dim0 with DIM0_BASE_SEL, then dim1 with DIM1_BASE_SEL. It pairs the two 16-bit fractions and presents them on a valid/ready output port, then advances k. It sits between the core and downstream consumers (sampling and placement logic) and adds seed load and a core watchdog.

Parameters:
DIM0_BASE_SEL, 2'b00, core base_sel for x (00=base2, 01=base3, 10=base7)
DIM1_BASE_SEL, 2'b01, core base_sel for y
K_START, 32'd1, index loaded at reset and on wrap
TIMEOUT_CYCLES, 256, max cycles waiting for core_done before error (>=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
run  in  1  level; 1 = generate points continuously
seed_we  in  1  load seed_k into index register (honoured only in IDLE)
seed_k  in  32  seed index
err_clr  in  1  clears err, ERR->IDLE
core_ready  in  1  core idle indication
core_done  in  1  core completion
core_result  in  32  core 16.16 result
core_start  out  1  one-cycle job start pulse
core_k  out  32  job index
core_base_sel  out  2  job base select
pt_valid  out  1  point available
pt_ready  in  1  consumer accepts
pt_x  out  16  dim0 fraction (core_result[15:0])
pt_y  out  16  dim1 fraction
pt_k  out  32  index of the presented point
busy  out  1  state != IDLE, HOLD, ERR
err  out  1  sticky watchdog error

Behaviour:
- Reset (async, rst=1): state IDLE, k_reg=K_START, all outputs 0 (core_start, core_k, core_base_sel, pt_valid, pt_x, pt_y, pt_k, busy, err), done_q=0, timer=0.
- All outputs are registered. core_start is high exactly one cycle, only in ISSUE0/ISSUE1.
- Completion detect: done_rise = core_done & ~done_q. Done is only accepted on a rising edge while in WAIT0/WAIT1, so a level-held done is never double-counted.
- IDLE: seed_we loads k_reg (seed_we has priority over run in the same cycle). If run & core_ready & ~seed_we, go to ISSUE0.
- ISSUE0: core_start=1, core_k=k_reg, core_base_sel=DIM0_BASE_SEL, timer cleared. Next state WAIT0.
- WAIT0: on done_rise, capture pt_x<=core_result[15:0] and go to ARM1. Otherwise timer++; when timer==TIMEOUT_CYCLES-1, go to ERR.
- ARM1: when core_ready, go to ISSUE1.
- ISSUE1: as ISSUE0, with DIM1_BASE_SEL.
- WAIT1: on done_rise, capture pt_y, set pt_k<=k_reg, pt_valid<=1, go to HOLD. Timeout handling as in WAIT0.
- HOLD: pt_valid, pt_x, pt_y, pt_k stay stable until pt_ready.
  - On pt_valid & pt_ready: pt_valid<=0; k_reg<=k_reg+1, or K_START if k_reg==32'hFFFFFFFF.
  - Then ISSUE0 if run & core_ready, else IDLE.
  - No core_start is issued while pt_valid=1.
- Latency with an ideal core (ready always high, done N cycles after start): first pt_valid = 2N+5 cycles after run rises in IDLE.
- run deasserted mid-point: the current point still completes to HOLD; IDLE is entered only after it is accepted.
- ERR: err=1, pt_valid=0, no core activity. err_clr goes to IDLE and clears err. k_reg is unchanged, so the failed index is retried.
- seed_we outside IDLE is ignored.
- A captured value with core_result[31:16]!=0 is not checked; only the low 16 bits are used.
- Reset mid-operation returns to the reset state immediately. The core shares rst and is reset alongside.

Decomposition:
- Shared package halton_pkg:
  - state enum (IDLE, ISSUE0, WAIT0, ARM1, ISSUE1, WAIT1, HOLD, ERR)
  - BASE_SEL_2/3/7 constants
  - FRAC_W=16, IDX_W=32
- One natural sub-module: halton_watchdog (loadable down-counter with expire flag), reusable by future multi-core schedulers.
- The core itself is instantiated at the level above, not inside this block.

Test Plan:
- Base 2/3 defaults, run=1, pt_ready=1, real core: three points are (k=1, 0x8000, 0x5555), (k=2, 0x4000, 0xAAAA), (k=3, 0xC000, 0x1C71), each within ±0x100.
- Seed k=11 in IDLE, run: first point is x=0xD000, y=0xB425, pt_k=11. Repeat with DIM1_BASE_SEL=2'b10: y=0x9782.
- Backpressure: pt_ready=0 for 20 cycles after pt_valid: outputs stable, core_start stays low, k does not advance. pt_ready=1 gives one handshake and the next point.
- Stub core that never asserts done, TIMEOUT_CYCLES=16: err rises 16 cycles after core_start and pt_valid stays 0. err_clr returns to IDLE, and the retry uses the same core_k.
- Seed 32'hFFFFFFFF: point with pt_k=0xFFFFFFFF, then the next point has pt_k=K_START=1.
- rst pulse during WAIT1: all outputs 0 in the same cycle and k_reg=1. After release with run=1, the first point is k=1.
